// File: rtl/apb4_cmd_master_if.sv
// Bundle of the local command/response port and the APB4 bus.
// The master modport is the requester's view; slave is the environment's.
interface apb4_cmd_master_if #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 32
);
  // command port
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;
  logic [3:0]           cmd_strb;
  logic [2:0]           cmd_prot;
  // response port
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;
  // APB4 bus
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDRWIDTH-1:0] paddr;
  logic [DATAWIDTH-1:0] pwdata;
  logic [3:0]           pstrb;
  logic [2:0]           pprot;
  logic [DATAWIDTH-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb4_cmd_master.sv
// Single-outstanding APB4 requester: one command in, one SETUP/ACCESS
// transfer out, one response held until consumed. An ACCESS watchdog
// aborts transfers whose slave never raises pready.
module apb4_cmd_master #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic               pclk,
  input  logic               preset,
  apb4_cmd_master_if.master  bus
);

  // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t               state_q,  state_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_q,  paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]           pstrb_q,  pstrb_d;
  logic [2:0]           pprot_q,  pprot_d;
  logic [DATAWIDTH-1:0] rdata_q,  rdata_d;
  logic                 err_q,    err_d;
  logic                 tmo_q,    tmo_d;

  // State register and captured bus/response fields.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state, capture and watchdog logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          // Reads never carry strobes on the bus.
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : 4'b0000;
          pprot_d  = bus.cmd_prot;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready is checked first so it wins over a same-cycle timeout.
        if (bus.pready) begin
          rdata_d = bus.pwrite ? '0 : bus.prdata;
          err_d   = bus.pslverr;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if ((TIMEOUT != 0) && (cnt_q == CW'(TLAST))) begin
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable     = (state_q == ACCESS);
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench for apb4_cmd_master with TIMEOUT=4: a vector table of
// whole transfers plus hand sequences for back-pressure and mid-ACCESS reset.
module tb_apb4_cmd_master;

  logic pclk;
  logic preset;
  int   n_checks;
  int   n_fail;

  apb4_cmd_master_if #(.ADDRWIDTH(12), .DATAWIDTH(32)) bus ();

  apb4_cmd_master #(.ADDRWIDTH(12), .DATAWIDTH(32), .TIMEOUT(4)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;      // pready=0 ACCESS cycles before pready=1
    logic [31:0] rdata_in;   // prdata driven with pready=1
    logic        perr;       // pslverr driven with pready=1
    logic        perr_wait;  // pslverr driven while pready=0
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_acc;    // ACCESS cycles observed
    int          exp_lat;    // cycles from handshake edge to rsp_valid
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int acc;
    logic got_rsp;
    logic [3:0] exp_strb;
    exp_strb = v.wr ? v.strb : 4'b0000;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.cmd_prot  = v.prot;
    bus.rsp_ready = 1'b0;
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'hF;
    lat = 0;
    acc = 0;
    got_rsp = 1'b0;
    while (lat < 40 && !got_rsp) begin
      lat++;
      if (bus.rsp_valid) begin
        got_rsp = 1'b1;
      end else begin
        chk("busy_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        if (lat == 1) begin
          chk("setup_psel", {31'd0, bus.psel}, 32'd1);
          chk("setup_penable", {31'd0, bus.penable}, 32'd0);
        end
        if (lat == 2) chk("access_penable", {31'd0, bus.penable}, 32'd1);
        if (bus.psel) begin
          chk("paddr", {20'd0, bus.paddr}, {20'd0, v.addr});
          chk("pwrite", {31'd0, bus.pwrite}, {31'd0, v.wr});
          chk("pstrb", {28'd0, bus.pstrb}, {28'd0, exp_strb});
          chk("pprot", {29'd0, bus.pprot}, {29'd0, v.prot});
          if (v.wr) chk("pwdata", bus.pwdata, v.wdata);
        end
        if (bus.psel && bus.penable) begin
          acc++;
          if (acc > v.waits) begin
            bus.pready  = 1'b1;
            bus.prdata  = v.rdata_in;
            bus.pslverr = v.perr;
          end else begin
            bus.pready  = 1'b0;
            bus.prdata  = 32'hDEAD_BEEF;
            bus.pslverr = v.perr_wait;
          end
        end else begin
          bus.pready  = 1'b0;
          bus.pslverr = 1'b0;
        end
        tick();
      end
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    chk("rsp_seen", {31'd0, got_rsp}, 32'd1);
    chk("latency", lat, v.exp_lat);
    chk("access_cycles", acc, v.exp_acc);
    chk("rsp_psel", {31'd0, bus.psel}, 32'd0);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, v.exp_tmo});
    $display("txn %0d: wr=%0d addr=0x%03h lat=%0d acc=%0d rdata=0x%08h err=%0d tmo=%0d",
             idx, v.wr, v.addr, lat, acc, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("post_rsp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            wr    addr     wdata          strb     prot  wt  rdata_in       perr  pw    exp_rdata      err   tmo  acc lat
    vecs[0] = '{1'b1, 12'h010, 32'hA5A5_0F0F, 4'b0101, 3'd0, 0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1, 3};
    vecs[1] = '{1'b0, 12'h004, 32'h1111_2222, 4'b1111, 3'd2, 3,  32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4, 6};
    vecs[2] = '{1'b1, 12'h008, 32'h0000_00FF, 4'b1111, 3'd1, 0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1, 3};
    vecs[3] = '{1'b1, 12'h00C, 32'hCAFE_BABE, 4'b1000, 3'd0, 1,  32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 2, 4};
    vecs[4] = '{1'b0, 12'h040, 32'h0,         4'b0000, 3'd0, 99, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4, 6};
    vecs[5] = '{1'b0, 12'h044, 32'h0,         4'b0000, 3'd3, 3,  32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 4, 6};
    vecs[6] = '{1'b0, 12'hFFC, 32'h0,         4'b0110, 3'd5, 2,  32'h8000_0001, 1'b1, 1'b0, 32'h8000_0001, 1'b1, 1'b0, 3, 5};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;

    // reset state
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_psel", {31'd0, bus.psel}, 32'd0);
    chk("rst_penable", {31'd0, bus.penable}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
    chk("rst_paddr", {20'd0, bus.paddr}, 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_pstrb", {28'd0, bus.pstrb}, 32'd0);
    chk("rst_pprot", {29'd0, bus.pprot}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Response back-pressure with a second command held at the port.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h020;
    bus.cmd_prot  = 3'd0;
    tick();                                  // handshake A
    bus.cmd_write = 1'b1;                    // command B held
    bus.cmd_addr  = 12'h030;
    bus.cmd_wdata = 32'h7777_0000;
    bus.cmd_strb  = 4'b0011;
    bus.pready    = 1'b1;
    bus.prdata    = 32'hCAFE_0001;
    tick();                                  // SETUP
    chk("bp_setup_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();                                  // ACCESS
    tick();                                  // RESP
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'hCAFE_0001);
      chk("bp_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("bp_psel", {31'd0, bus.psel}, 32'd0);
      tick();
    end
    $display("txn bp_A: read addr=0x020 rdata=0x%08h held 5 cycles", bus.rsp_rdata);
    bus.rsp_ready = 1'b1;
    tick();                                  // IDLE, B accepted at next edge
    bus.rsp_ready = 1'b0;
    chk("bp_idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("bp_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();                                  // SETUP of B
    bus.cmd_valid = 1'b0;
    chk("bp_b_psel", {31'd0, bus.psel}, 32'd1);
    chk("bp_b_paddr", {20'd0, bus.paddr}, 32'h030);
    chk("bp_b_pwrite", {31'd0, bus.pwrite}, 32'd1);
    chk("bp_b_pstrb", {28'd0, bus.pstrb}, 32'h3);
    bus.pready = 1'b1;
    tick();                                  // ACCESS
    tick();                                  // RESP
    bus.pready = 1'b0;
    chk("bp_b_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_b_rsp_rdata", bus.rsp_rdata, 32'd0);
    $display("txn bp_B: write addr=0x030 rsp_valid=%0d err=%0d", bus.rsp_valid, bus.rsp_err);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during a pready=0 ACCESS wait.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h050;
    tick();                                  // handshake
    bus.cmd_valid = 1'b0;
    tick();                                  // SETUP -> ACCESS
    chk("mid_penable", {31'd0, bus.penable}, 32'd1);
    tick();                                  // still ACCESS, waiting
    chk("mid_penable2", {31'd0, bus.penable}, 32'd1);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    chk("mid_rst_psel", {31'd0, bus.psel}, 32'd0);
    chk("mid_rst_penable", {31'd0, bus.penable}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    $display("txn mid_reset: psel=%0d penable=%0d cmd_ready=%0d", bus.psel, bus.penable, bus.cmd_ready);
    // A fresh counter must allow a full 3-wait read after the reset.
    run_vec(100, vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/apb4_cmd_master.md
# apb4_cmd_master

Single-outstanding APB4 requester. Converts a valid/ready command port from a local controller into APB4 SETUP/ACCESS transfers toward the register slaves, and returns read data and error status on a response port held until consumed. Sits between the subsystem control logic and the APB4 slave register blocks. An ACCESS-phase watchdog terminates any transfer whose slave never asserts pready.

## Interface
- ADDRWIDTH, 12, width of cmd_addr and paddr
- DATAWIDTH, 32, width of read and write data (32 only)
- TIMEOUT, 256, maximum ACCESS cycles without pready before abort; 0 disables the watchdog
- pclk  input  1  clock
- preset  input  1  reset; synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDRWIDTH  byte address
- cmd_wdata  input  DATAWIDTH  write data
- cmd_strb  input  4  write byte enables
- cmd_prot  input  3  pprot value for this transfer
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  output  DATAWIDTH  read data; 0 for writes and timeouts
- rsp_err  output  1  pslverr seen, or timeout
- rsp_timeout  output  1  transfer aborted by watchdog
- psel, penable, pwrite  output  1 each  APB4 control
- paddr  output  ADDRWIDTH  APB4 address
- pwdata  output  DATAWIDTH  APB4 write data
- pstrb  output  4  APB4 strobes
- pprot  output  3  APB4 protection
- prdata  input  DATAWIDTH  APB4 read data
- pready  input  1  APB4 ready
- pslverr  input  1  APB4 slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state: IDLE.
- IDLE: cmd_ready=1. On a command handshake, capture write/addr/wdata/strb/prot and go to SETUP.
- SETUP: psel=1, penable=0. Always go to ACCESS after one cycle.
- ACCESS: psel=1, penable=1. If pready=1:
  - capture prdata (reads only; writes capture 0) and pslverr into rsp_err.
  - go to RESP.
- ACCESS, pready=0, watchdog:
  - an ACCESS-cycle counter, width clog2(TIMEOUT+1), increments.
  - when TIMEOUT≠0 and the count reaches TIMEOUT, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - the counter clears when entering SETUP.
- RESP: psel=penable=0, rsp_valid=1. On rsp_ready go to IDLE. The response fields hold stable until the handshake.
- Address, data, strobe and prot outputs hold their captured values from SETUP through the last ACCESS cycle.
- pstrb is forced to 4'b0000 on reads, regardless of cmd_strb.
- Outside SETUP/ACCESS, pwrite/paddr/pwdata/pstrb/pprot keep their last values; only psel/penable are guaranteed 0.
- pslverr and prdata are ignored unless psel & penable & pready.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Only one transfer is ever outstanding.

## Timing
- Reset (preset=1 at a pclk edge): next cycle all outputs are 0, except cmd_ready=1; state is IDLE.
- Reset takes effect from any state, including mid-ACCESS. It drops psel/penable immediately, discards the pending response and clears the counter.
- Minimum latency, handshake at edge 0:
  - SETUP during cycle 1, ACCESS during cycle 2.
  - with pready=1 in cycle 2, rsp_valid=1 in cycle 3.
  - if rsp_ready=1 in cycle 3, cmd_ready=1 in cycle 4.
- Throughput: a zero-wait-state transfer takes 4 cycles per command with rsp_ready tied high.
- Each pready=0 cycle in ACCESS adds one cycle of latency.
- Watchdog: with TIMEOUT=N, abort occurs after exactly N consecutive ACCESS cycles with pready=0; rsp_valid rises the next cycle.
- pready=1 on the same cycle the count reaches N: the transfer completes normally; pready wins over the timeout.
- Commands presented while busy are not accepted and must be held by the source; cmd_ready does not depend combinationally on cmd_valid.

## Test plan
- Write with zero wait states:
  - stimulus: addr 0x010, data 0xA5A5_0F0F, strb 4'b0101, pready tied high.
  - required: psel rises the cycle after the handshake, penable the next; pwdata/pstrb match the command.
  - required: rsp_valid 3 cycles after the handshake, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - stimulus: addr 0x004; slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x1234_5678.
  - required: pstrb=0 throughout; rsp_rdata=0x1234_5678; rsp_valid 6 cycles after the handshake.
- Slave error:
  - stimulus: write; pready=1 with pslverr=1.
  - required: rsp_err=1, rsp_timeout=0.
  - stimulus: then pslverr=1 while pready=0 for one cycle, followed by pready=1/pslverr=0.
  - required: rsp_err=0.
- Timeout with TIMEOUT=4:
  - stimulus: pready held 0.
  - required: exactly 4 ACCESS cycles, then psel=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - stimulus: repeat with pready=1 on the 4th ACCESS cycle.
  - required: normal completion.
- Response back-pressure:
  - stimulus: rsp_ready=0 for 5 cycles while cmd_valid is held with a second command.
  - required: rsp fields stable, cmd_ready=0, psel=0; the second command is accepted the cycle after rsp_ready=1.
- Reset mid-ACCESS:
  - stimulus: preset=1 for one cycle during a pready=0 wait.
  - required: next cycle psel=penable=rsp_valid=0 and cmd_ready=1; a subsequent read completes normally.
